delay_line_checker: RTL and testbench

// - Receive-side checker for delay-line tests: samples the delay-line output and checks it against the stimulus pattern.
// - The stimulus is a WIDTH-bit up-counter that holds each value for exactly DELAY+1 clocks and wraps mod 2^WIDTH.
// - The checker locks onto the stream, flags every broken value or run length, and counts errors.
// - Sits at the output of the delay line under test; synthesizable, so it can also run in hardware.

---
 rtl/delay_line_checker_pkg.sv | 16 +
 rtl/delay_line_run_counter.sv | 40 ++++
 rtl/delay_line_checker.sv | 136 +++++++++++++
 tb/tb_delay_line_checker.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/delay_line_checker_pkg.sv
// Shared types and sizing helpers for the delay-line checker.
package delay_line_checker_pkg;

  // Lock FSM states
  typedef enum logic [1:0] {
    ACQUIRE = 2'd0,
    SYNC    = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  // Run-length counter width: must represent 0 .. delay+2
  function automatic int unsigned run_w(input int unsigned delay);
    return $clog2(delay + 3);
  endfunction

endpackage

// File: rtl/delay_line_run_counter.sv
// Tracks the previous sample and the length of the current run of equal values.
module delay_line_run_counter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DELAY = 3,
  parameter int unsigned RUN_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] prev,
  output logic [RUN_W-1:0] run_cnt,
  output logic             is_trans,
  output logic             is_succ
);

  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(DELAY + 2);

  // Classify the current sample against the previous one
  always_comb begin
    is_trans = (data != prev);
    is_succ  = (data == WIDTH'(prev + WIDTH'(1)));
  end

  // Previous value and saturating run length, advanced only on enabled samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev    <= '0;
      run_cnt <= '0;
    end else if (en) begin
      prev <= data;
      if (is_trans) begin
        run_cnt <= RUN_W'(1);
      end else if (run_cnt != RUN_MAX) begin
        run_cnt <= run_cnt + RUN_W'(1);
      end
    end
  end

endmodule

// File: rtl/delay_line_checker.sv
// Locks onto a held up-counter stream from a delay line and flags/counts violations.
module delay_line_checker
  import delay_line_checker_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DELAY     = 3,
  parameter int unsigned LOCK_RUNS = 2,
  parameter int unsigned ERR_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] data,
  output logic             locked,
  output logic             error,
  output logic [ERR_W-1:0] err_count,
  output logic [ERR_W-1:0] good_count
);

  localparam int unsigned      RUN_W    = run_w(DELAY);
  localparam int unsigned      GOOD_W   = $clog2(LOCK_RUNS + 1);
  localparam logic [RUN_W-1:0] RUN_FULL = RUN_W'(DELAY + 1);
  localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_RUNS - 1);

  state_t              state;
  state_t              state_nxt;
  logic [GOOD_W-1:0]   good;
  logic [GOOD_W-1:0]   good_nxt;
  logic                error_nxt;
  logic                err_inc;
  logic                good_inc;
  logic                good_trans;

  logic [WIDTH-1:0]    prev;
  logic [RUN_W-1:0]    run_cnt;
  logic                is_trans;
  logic                is_succ;

  delay_line_run_counter #(
    .WIDTH (WIDTH),
    .DELAY (DELAY),
    .RUN_W (RUN_W)
  ) u_run_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .data     (data),
    .prev     (prev),
    .run_cnt  (run_cnt),
    .is_trans (is_trans),
    .is_succ  (is_succ)
  );

  // Next state, lock progress and violation decode for the current sample
  always_comb begin
    state_nxt  = state;
    good_nxt   = good;
    error_nxt  = 1'b0;
    err_inc    = 1'b0;
    good_inc   = 1'b0;
    good_trans = is_trans && is_succ && (run_cnt == RUN_FULL);
    if (en) begin
      unique case (state)
        ACQUIRE: begin
          if (is_trans) begin
            state_nxt = SYNC;
            good_nxt  = '0;
          end
        end
        SYNC: begin
          if (is_trans) begin
            if (good_trans) begin
              if (good == GOOD_LAST) begin
                state_nxt = LOCKED;
                good_nxt  = '0;
              end else begin
                good_nxt = good + GOOD_W'(1);
              end
            end else begin
              good_nxt = '0;
            end
          end else if (run_cnt >= RUN_FULL) begin
            // this sample stretches the run past full length
            state_nxt = ACQUIRE;
            good_nxt  = '0;
          end
        end
        LOCKED: begin
          if (is_trans) begin
            if (good_trans) begin
              good_inc = 1'b1;
            end else begin
              error_nxt = 1'b1;
              err_inc   = 1'b1;
              state_nxt = SYNC;
              good_nxt  = '0;
            end
          end else if (run_cnt >= RUN_FULL) begin
            error_nxt = 1'b1;
            err_inc   = 1'b1;
            state_nxt = ACQUIRE;
            good_nxt  = '0;
          end
        end
        default: begin
          state_nxt = ACQUIRE;
          good_nxt  = '0;
        end
      endcase
    end
  end

  // State, registered outputs and saturating counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ACQUIRE;
      good       <= '0;
      locked     <= 1'b0;
      error      <= 1'b0;
      err_count  <= '0;
      good_count <= '0;
    end else begin
      state  <= state_nxt;
      good   <= good_nxt;
      locked <= (state_nxt == LOCKED);
      error  <= error_nxt;
      if (err_inc && (err_count != '1)) begin
        err_count <= err_count + ERR_W'(1);
      end
      if (good_inc && (good_count != '1)) begin
        good_count <= good_count + ERR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_delay_line_checker.sv
// Scoreboard bench for delay_line_checker (WIDTH=4, DELAY=2, LOCK_RUNS=2).
module tb_delay_line_checker;

  localparam int DELAY     = 2;
  localparam int LOCK_RUNS = 2;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [3:0]  data;
  logic        locked, error;
  logic [15:0] err_count, good_count;
  logic        locked_s, error_s;
  logic [1:0]  err_count_s, good_count_s;

  typedef struct {
    logic        locked;
    logic        error;
    logic [15:0] ec;
    logic [15:0] gc;
    logic [1:0]  ec_s;
    logic [1:0]  gc_s;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  int m_state, m_good, m_prev, m_run, m_ec, m_gc;
  bit m_err;

  delay_line_checker #(.WIDTH(4), .DELAY(DELAY), .LOCK_RUNS(LOCK_RUNS), .ERR_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .data(data),
    .locked(locked), .error(error), .err_count(err_count), .good_count(good_count)
  );

  delay_line_checker #(.WIDTH(4), .DELAY(DELAY), .LOCK_RUNS(LOCK_RUNS), .ERR_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .data(data),
    .locked(locked_s), .error(error_s), .err_count(err_count_s), .good_count(good_count_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    m_state = 0; m_good = 0; m_prev = 0; m_run = 0; m_ec = 0; m_gc = 0; m_err = 0;
  endtask

  // Behavioural reference: what the checker should conclude from one sample
  task automatic model_step(input bit e, input int d);
    bit trans, succ, full, ok;
    m_err = 0;
    if (!e) return;
    trans = (d != m_prev);
    succ  = (d == ((m_prev + 1) % 16));
    full  = (m_run == DELAY + 1);
    ok    = trans && succ && full;
    case (m_state)
      0: if (trans) begin m_state = 1; m_good = 0; end
      1: begin
        if (trans) begin
          if (ok) begin
            m_good++;
            if (m_good == LOCK_RUNS) begin m_state = 2; m_good = 0; end
          end else m_good = 0;
        end else if (m_run + 1 > DELAY + 1) begin
          m_state = 0; m_good = 0;
        end
      end
      default: begin
        if (trans) begin
          if (ok) m_gc++;
          else begin m_err = 1; m_ec++; m_state = 1; m_good = 0; end
        end else if (full) begin
          m_err = 1; m_ec++; m_state = 0; m_good = 0;
        end
      end
    endcase
    m_prev = d;
    if (trans) m_run = 1;
    else if (m_run < DELAY + 2) m_run++;
  endtask

  task automatic step(input bit e, input int d);
    exp_t x, got_exp;
    @(negedge clk);
    en   = e;
    data = 4'(d);
    model_step(e, d);
    x.locked = (m_state == 2);
    x.error  = m_err;
    x.ec     = 16'(sat(m_ec, 65535));
    x.gc     = 16'(sat(m_gc, 65535));
    x.ec_s   = 2'(sat(m_ec, 3));
    x.gc_s   = 2'(sat(m_gc, 3));
    sb.push_back(x);
    @(posedge clk);
    #1;
    got_exp = sb.pop_front();
    check("locked", 32'(locked), 32'(got_exp.locked));
    check("error", 32'(error), 32'(got_exp.error));
    check("err_count", 32'(err_count), 32'(got_exp.ec));
    check("good_count", 32'(good_count), 32'(got_exp.gc));
    check("sat_error", 32'(error_s), 32'(got_exp.error));
    check("sat_err_count", 32'(err_count_s), 32'(got_exp.ec_s));
    check("sat_good_count", 32'(good_count_s), 32'(got_exp.gc_s));
  endtask

  task automatic run_val(input int v, input int n);
    for (int i = 0; i < n; i++) step(1'b1, v % 16);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_locked"}, 32'(locked), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
    check({tag, "_err_count"}, 32'(err_count), 32'd0);
    check({tag, "_good_count"}, 32'(good_count), 32'd0);
    check({tag, "_sat_err_count"}, 32'(err_count_s), 32'd0);
  endtask

  initial begin
    int cur;
    int ec_before;
    int gc_before;
    rst_n = 1'b0;
    en    = 1'b0;
    data  = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // lock-in, then count up through the wrap
    run_val(1, 2);
    for (int v = 2; v <= 13; v++) run_val(v, 3);
    check("locked_after_lockin", 32'(locked), 32'd1);
    run_val(14, 3); run_val(15, 3); run_val(0, 3); run_val(1, 3);
    check("no_error_through_wrap", 32'(err_count), 32'd0);

    // skipped value
    for (int v = 2; v <= 5; v++) run_val(v, 3);
    run_val(7, 1);
    check("skip_err_count", 32'(err_count), 32'd1);
    check("skip_unlocked", 32'(locked), 32'd0);
    run_val(7, 2); run_val(8, 3); run_val(9, 1);
    check("relock_after_skip", 32'(locked), 32'd1);
    run_val(9, 2);

    // short run, relock, then stuck
    run_val(10, 3); run_val(11, 2); run_val(12, 1);
    run_val(12, 2); run_val(13, 3); run_val(14, 1); run_val(14, 2);
    run_val(15, 3); run_val(0, 4);
    check("stuck_err_count", 32'(err_count), 32'd3);

    // reacquire and lock again
    run_val(1, 3); run_val(2, 3); run_val(3, 1); run_val(3, 2);

    // en gaps with garbage data between locked samples
    ec_before = int'(err_count);
    gc_before = int'(good_count);
    for (int v = 4; v <= 7; v++) begin
      for (int k = 0; k < 3; k++) begin
        step(1'b1, v);
        step(1'b0, int'($urandom_range(0, 15)));
      end
    end
    check("gap_err_count", 32'(err_count), 32'(ec_before));
    check("gap_good_count", 32'(good_count), 32'(gc_before + 4));

    // three more violations to drive the 2-bit counter past saturation
    cur = 7;
    for (int k = 0; k < 3; k++) begin
      cur = cur + 2;
      run_val(cur, 1);
      run_val(cur, 2); run_val(cur + 1, 3); run_val(cur + 2, 1); run_val(cur + 2, 2);
      cur = cur + 2;
    end
    check("sat_holds_at_3", 32'(err_count_s), 32'd3);
    check("wide_err_count", 32'(err_count), 32'd6);

    // async reset while locked, no clock edge in between
    check("locked_before_reset", 32'(locked), 32'd1);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    run_val(5, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
